// File: rtl/wishbone_master_barrier.sv
// Request-path barrier between a Wishbone master and slave. Holds one request
// until ACK, backs off and reissues on RTY, and drains after ACK.
module wishbone_master_barrier #(
    parameter int unsigned BACKOFF_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CYC_in,
    input  logic         STB_in,
    input  logic         WE_in,
    input  logic [15:0]  SEL_in,
    input  logic [31:0]  ADR_in,
    input  logic [127:0] DAT_M_in,
    input  logic         ACK_in,
    input  logic         RTY_in,
    output logic         CYC_out,
    output logic         STB_out,
    output logic         WE_out,
    output logic [15:0]  SEL_out,
    output logic [31:0]  ADR_out,
    output logic [127:0] DAT_M_out,
    output logic [7:0]   retry_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StBackoff, StDrain} state_e;

    localparam logic [31:0] BackoffLoad = 32'(BACKOFF_CYCLES - 1);
    localparam logic [31:0] DrainLoad   = 32'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic          we_q, we_d;
    logic [15:0]   sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [127:0]  dat_q, dat_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle: begin
                if (CYC_in && STB_in) begin
                    we_d    = WE_in;
                    sel_d   = SEL_in;
                    adr_d   = ADR_in;
                    dat_d   = DAT_M_in;
                    retry_d = 8'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // ACK wins over a simultaneous RTY
                if (ACK_in) begin
                    cnt_d   = DrainLoad;
                    state_d = StDrain;
                end else if (RTY_in) begin
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                    cnt_d   = BackoffLoad;
                    state_d = StBackoff;
                end else if (!CYC_in) begin
                    state_d = StIdle;
                end
            end
            StBackoff: begin
                if (!CYC_in) begin
                    state_d = StIdle;
                end else if (cnt_q == 32'd0) begin
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StDrain: begin
                if (cnt_q == 32'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            retry_q <= 8'd0;
            we_q    <= 1'b0;
            sel_q   <= 16'd0;
            adr_q   <= 32'd0;
            dat_q   <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    // Strobes decode the state register only, so no input reaches an output.
    assign CYC_out   = (state_q == StIssue) || (state_q == StBackoff);
    assign STB_out   = (state_q == StIssue);
    assign WE_out    = we_q;
    assign SEL_out   = sel_q;
    assign ADR_out   = adr_q;
    assign DAT_M_out = dat_q;
    assign retry_cnt = retry_q;

endmodule
